// File: rtl/matrix_result_drain.sv
// matrix_result_drain: waits a fixed latency after start, snapshots matrix_mult's C
// and streams its N*N elements row-major over a valid/ready handshake.
module matrix_result_drain #(
    parameter int N       = 4,
    parameter int WIDTH   = 16,
    parameter int LATENCY = 6,
    localparam int OW     = 2*WIDTH,
    localparam int RW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N*N*OW-1:0] c_flat,
    output logic [OW-1:0]     out_data,
    output logic [RW-1:0]     out_row,
    output logic [RW-1:0]     out_col,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              start_drop
);
    localparam int NN = N*N;
    localparam int IW = $clog2(NN+1);
    localparam int AW = (NN > 1) ? $clog2(NN) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NN-1);
    localparam logic [RW-1:0] LAST_COL = RW'(N-1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY-1);

    typedef enum logic [1:0] {IDLE, WAIT, STREAM} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d, nxt_idx;
    logic [OW-1:0]   buf_q [NN];
    logic [OW-1:0]   data_q, data_d;
    logic [RW-1:0]   row_q, row_d, col_q, col_d;
    logic            valid_q, valid_d, last_q, last_d;
    logic            done_q, done_d, drop_q, drop_d;
    logic            capture;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        row_d   = row_q;
        col_d   = col_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        drop_d  = start && (state_q != IDLE);
        capture = 1'b0;
        nxt_idx = idx_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    // Element 0 is presented straight from c_flat so it is visible the cycle after capture.
                    capture = 1'b1;
                    state_d = STREAM;
                    idx_d   = '0;
                    data_d  = c_flat[OW-1:0];
                    row_d   = '0;
                    col_d   = '0;
                    valid_d = 1'b1;
                    last_d  = (NN == 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STREAM: begin
                if (out_ready && last_q) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    data_d  = '0;
                    row_d   = '0;
                    col_d   = '0;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (out_ready) begin
                    idx_d  = nxt_idx;
                    data_d = buf_q[nxt_idx[AW-1:0]];
                    col_d  = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
                    row_d  = (col_q == LAST_COL) ? row_q + 1'b1 : row_q;
                    last_d = (nxt_idx == LAST_IDX);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            row_q   <= row_d;
            col_q   <= col_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NN; k++) buf_q[k] <= '0;
        end else if (capture) begin
            for (int k = 0; k < NN; k++) buf_q[k] <= c_flat[k*OW +: OW];
        end
    end

    assign out_data   = data_q;
    assign out_row    = row_q;
    assign out_col    = col_q;
    assign out_valid  = valid_q;
    assign out_last   = last_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign start_drop = drop_q;
endmodule
